// File: rtl/sha256_pkg.sv
// Shared constants and state encoding for the SHA-256 digest target checker.
package sha256_pkg;
    localparam int NUM_HASH_WORDS = 8;
    localparam int RESULT_HIT_BIT = 31;
    localparam int RESULT_LZ_MSB  = 8;

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
endpackage

// File: rtl/sha256_clz32.sv
// Combinational count-leading-zeros of a 32-bit word; returns 32 for zero input.
module sha256_clz32 (
    input  logic [31:0] i_val,
    output logic [5:0]  o_clz
);
    // Ascending scan: the highest set bit is the last one to assign.
    always_comb begin
        o_clz = 6'd32;
        for (int i = 0; i < 32; i++) begin
            if (i_val[i]) o_clz = 6'(31 - i);
        end
    end
endmodule

// File: rtl/sha256_target_check.sv
// Reads back the 8-word digest, compares it with the latched target, counts leading
// zeros and writes one {hit, lz} result word.
module sha256_target_check
    import sha256_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [15:0]  hash_addr,
    input  logic [15:0]  result_addr,
    input  logic [255:0] target,
    output logic         done,
    output logic         mem_clk,
    output logic         mem_we,
    output logic [15:0]  mem_addr,
    output logic [31:0]  mem_write_data,
    input  logic [31:0]  mem_read_data,
    output logic         hit,
    output logic [8:0]   lz_count
);
    state_t         r_state;
    logic [3:0]     r_idx;
    logic [255:0]   r_target;
    logic [15:0]    r_hash_addr;
    logic [15:0]    r_result_addr;
    logic           r_decided;
    logic           r_less;
    logic           r_still_zero;
    logic [8:0]     r_lz;
    logic           r_mem_we;
    logic [15:0]    r_mem_addr;
    logic [31:0]    r_mem_wdata;
    logic           r_hit;
    logic [8:0]     r_lz_count;

    logic [2:0]     w_w;
    logic [7:0]     w_tsel;
    logic [31:0]    w_tw;
    logic [5:0]     w_clz;
    logic           w_decided_n;
    logic           w_less_n;
    logic           w_still_zero_n;
    logic [8:0]     w_lz_n;
    logic           w_hit_n;
    logic [31:0]    w_result;

    assign mem_clk        = clk;
    assign done           = (r_state == IDLE);
    assign mem_we         = r_mem_we;
    assign mem_addr       = r_mem_addr;
    assign mem_write_data = r_mem_wdata;
    assign hit            = r_hit;
    assign lz_count       = r_lz_count;

    // Read data arriving at idx belongs to word idx-1; word 0 sits in target[255:224].
    assign w_w    = 3'(r_idx - 4'd1);
    assign w_tsel = {~w_w, 5'd0};
    assign w_tw   = r_target[w_tsel +: 32];

    sha256_clz32 u_clz (
        .i_val (mem_read_data),
        .o_clz (w_clz)
    );

    assign w_decided_n    = r_decided | (mem_read_data != w_tw);
    assign w_less_n       = r_decided ? r_less : (mem_read_data < w_tw);
    assign w_still_zero_n = r_still_zero & (mem_read_data == 32'd0);
    assign w_lz_n         = r_still_zero ? (r_lz + {3'd0, w_clz}) : r_lz;
    assign w_hit_n        = w_less_n | ~w_decided_n;

    always_comb begin
        w_result                      = '0;
        w_result[RESULT_HIT_BIT]      = w_hit_n;
        w_result[RESULT_LZ_MSB:0]     = w_lz_n;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_idx         <= '0;
            r_target      <= '0;
            r_hash_addr   <= '0;
            r_result_addr <= '0;
            r_decided     <= 1'b0;
            r_less        <= 1'b0;
            r_still_zero  <= 1'b1;
            r_lz          <= '0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_hit         <= 1'b0;
            r_lz_count    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_mem_we <= 1'b0;
                    if (start) begin
                        r_target      <= target;
                        r_hash_addr   <= hash_addr;
                        r_result_addr <= result_addr;
                        r_idx         <= '0;
                        r_decided     <= 1'b0;
                        r_less        <= 1'b0;
                        r_still_zero  <= 1'b1;
                        r_lz          <= '0;
                        r_mem_addr    <= hash_addr;
                        r_state       <= READ;
                    end
                end
                READ: begin
                    if (r_idx != 4'd0) begin
                        r_decided    <= w_decided_n;
                        r_less       <= w_less_n;
                        r_still_zero <= w_still_zero_n;
                        r_lz         <= w_lz_n;
                    end
                    if (r_idx < 4'(NUM_HASH_WORDS - 1))
                        r_mem_addr <= r_hash_addr + {12'd0, r_idx} + 16'd1;
                    if (r_idx == 4'(NUM_HASH_WORDS)) begin
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= r_result_addr;
                        r_mem_wdata <= w_result;
                        r_hit       <= w_hit_n;
                        r_lz_count  <= w_lz_n;
                        r_state     <= WRITE;
                    end else begin
                        r_idx <= r_idx + 4'd1;
                    end
                end
                WRITE: begin
                    r_mem_we <= 1'b0;
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sha256_target_check.sv
// Randomized bench for sha256_target_check against a 256-bit arithmetic reference model.
module tb_sha256_target_check;
    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic [15:0]  hash_addr;
    logic [15:0]  result_addr;
    logic [255:0] target;
    logic         done;
    logic         mem_clk;
    logic         mem_we;
    logic [15:0]  mem_addr;
    logic [31:0]  mem_write_data;
    logic [31:0]  mem_read_data;
    logic         hit;
    logic [8:0]   lz_count;

    int checks = 0;
    int passes = 0;

    logic [31:0] img [0:65535];
    int          wr_cnt = 0;
    logic [15:0] wr_addr;
    logic [31:0] wr_data;

    sha256_target_check dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .hash_addr      (hash_addr),
        .result_addr    (result_addr),
        .target         (target),
        .done           (done),
        .mem_clk        (mem_clk),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data),
        .hit            (hit),
        .lz_count       (lz_count)
    );

    always #5 clk = ~clk;

    // Single-port memory: read data valid the cycle after the address; writes logged.
    always @(posedge clk) begin
        mem_read_data <= img[mem_addr];
        if (mem_we) begin
            wr_cnt  <= wr_cnt + 1;
            wr_addr <= mem_addr;
            wr_data <= mem_write_data;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    function automatic logic [31:0] model_word(input logic [255:0] d, input logic [255:0] t);
        logic h;
        int   lz;
        h  = (d <= t);
        lz = 256;
        for (int i = 255; i >= 0; i--) begin
            if (d[i]) begin
                lz = 255 - i;
                break;
            end
        end
        return {h, 22'd0, 9'(lz)};
    endfunction

    task automatic run(input logic [255:0] dig, input logic [255:0] tgt,
                       input logic [15:0] ha, input logic [15:0] ra,
                       input bit hold, input bit lit_en, input logic [31:0] lit);
        logic [31:0] exp;
        int          wr0, lowc;
        bit          seen;
        for (int i = 0; i < 8; i++) img[16'(ha + 16'(i))] = dig[255 - 32*i -: 32];
        exp = model_word(dig, tgt);
        if (lit_en) begin
            chk("model_pin", {32'd0, exp}, {32'd0, lit});
        end
        wr0         = wr_cnt;
        hash_addr   = ha;
        result_addr = ra;
        target      = tgt;
        start       = 1'b1;
        @(posedge clk);
        lowc = 0;
        seen = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1 && !hold) start = 1'b0;
            if (k <= 8) chk("rd_addr", {48'd0, mem_addr}, {48'd0, 16'(ha + 16'(k - 1))});
            if (done) begin
                seen = 1;
                break;
            end
            if (k < 10) chk("we_idle", {63'd0, mem_we}, 64'd0);
            if (k == 10) begin
                chk("wr_we",   {63'd0, mem_we}, 64'd1);
                chk("wr_addr", {48'd0, mem_addr}, {48'd0, ra});
                chk("wr_data", {32'd0, mem_write_data}, {32'd0, exp});
                chk("hit_wr",  {63'd0, hit}, {63'd0, exp[31]});
            end
            // Port changes after acceptance must not matter.
            if (k == 3) begin
                target      = ~tgt;
                hash_addr   = ~ha;
                result_addr = ~ra;
            end
            lowc++;
        end
        chk("done_seen", {63'd0, seen}, 64'd1);
        chk("busy_cycles", 64'(lowc), 64'd10);
        chk("hit", {63'd0, hit}, {63'd0, exp[31]});
        chk("lz_count", {55'd0, lz_count}, {55'd0, exp[8:0]});
        chk("wr_count", 64'(wr_cnt - wr0), 64'd1);
        chk("mem_result", {16'd0, wr_addr, wr_data}, {16'd0, ra, exp});
        if (lit_en) chk("lit_word", {32'd0, wr_data}, {32'd0, lit});
    endtask

    task automatic run_reset(input logic [255:0] dig, input logic [255:0] tgt,
                             input logic [15:0] ha, input logic [15:0] ra);
        int wr0;
        for (int i = 0; i < 8; i++) img[16'(ha + 16'(i))] = dig[255 - 32*i -: 32];
        wr0         = wr_cnt;
        hash_addr   = ha;
        result_addr = ra;
        target      = tgt;
        start       = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
        end
        reset_n = 1'b0;
        #1;
        chk("rst_done", {63'd0, done}, 64'd1);
        chk("rst_hit", {63'd0, hit}, 64'd0);
        chk("rst_lz", {55'd0, lz_count}, 64'd0);
        chk("rst_we", {63'd0, mem_we}, 64'd0);
        chk("rst_addr", {48'd0, mem_addr}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_idle", {63'd0, done}, 64'd1);
        chk("rst_nowrite", 64'(wr_cnt - wr0), 64'd0);
    endtask

    function automatic logic [31:0] rnd_word();
        case ($urandom_range(0, 3))
            0:       return 32'd0;
            1:       return $urandom;
            2:       return $urandom >> $urandom_range(0, 31);
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [255:0] d, t;
        logic [15:0]  ha;
        int           nz;
        reset_n     = 1'b0;
        start       = 1'b0;
        hash_addr   = '0;
        result_addr = '0;
        target      = '0;
        repeat (3) @(negedge clk);
        chk("rst_state_done", {63'd0, done}, 64'd1);
        chk("rst_state_we", {63'd0, mem_we}, 64'd0);
        chk("rst_state_addr", {48'd0, mem_addr}, 64'd0);
        chk("rst_state_wdata", {32'd0, mem_write_data}, 64'd0);
        chk("rst_state_hit", {63'd0, hit}, 64'd0);
        chk("rst_state_lz", {55'd0, lz_count}, 64'd0);
        chk("mem_clk", {63'd0, mem_clk}, {63'd0, clk});
        reset_n = 1'b1;
        @(negedge clk);

        run('0, '0, 16'h0010, 16'h0100, 0, 1, 32'h8000_0100);
        run({32'h0, 32'h0000_FFFF, {6{32'hFFFF_FFFF}}}, {32'h0, 32'h0001_0000, 192'h0},
            16'h0200, 16'h0300, 0, 1, 32'h8000_0030);
        run({8{32'h0F0F_0F0F}}, {8{32'h0F0F_0F0F}}, 16'h0400, 16'h0500, 0, 1, 32'h8000_0004);
        run({{7{32'h0F0F_0F0F}}, 32'h0F0F_0F10}, {8{32'h0F0F_0F0F}}, 16'h0400, 16'h0500,
            0, 1, 32'h0000_0004);
        run({8{32'hFFFF_FFFF}}, {{7{32'hFFFF_FFFF}}, 32'hFFFF_FFFE}, 16'h0600, 16'h0700,
            0, 1, 32'h0000_0000);

        // Back-to-back runs with start held; digest wraps the top of the address space.
        run({32'h0000_0001, {7{32'h1234_5678}}}, {32'h0000_0001, {7{32'h1234_5679}}},
            16'hFFFC, 16'h0100, 1, 1, 32'h8000_001F);
        run({32'h0, 32'h0, 32'h00F0_0000, {5{32'hABCD_0000}}}, {32'h0, 32'h0, 32'h00EF_FFFF, {5{32'h0}}},
            16'hFFFC, 16'h0100, 1, 1, 32'h0000_0048);
        start = 1'b0;
        @(negedge clk);

        run_reset({8{32'h0000_0001}}, '1, 16'h0800, 16'h0900);
        run({8{32'h0000_0001}}, '1, 16'h0800, 16'h0900, 0, 1, 32'h8000_001F);

        for (int r = 0; r < 14; r++) begin
            nz = $urandom_range(0, 4);
            for (int i = 0; i < 8; i++) d[255 - 32*i -: 32] = (i < nz) ? 32'd0 : rnd_word();
            case ($urandom_range(0, 3))
                0: for (int i = 0; i < 8; i++) t[255 - 32*i -: 32] = (i < nz) ? 32'd0 : rnd_word();
                1: t = d;
                2: t = d + 256'd1;
                default: t = d - 256'd1;
            endcase
            ha = 16'($urandom);
            run(d, t, ha, 16'(ha + 16'd8 + 16'($urandom_range(0, 1000))), 0, 0, 32'd0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
